next_pc_ctrl: RTL

NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

---
 rtl/next_pc_ctrl_pkg.sv | 23 ++
 rtl/next_pc_ctrl_if.sv | 33 +++
 rtl/next_pc_ctrl_step_debounce.sv | 45 ++++
 rtl/next_pc_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/next_pc_ctrl_pkg.sv
// Shared opcode constants, FSM encoding and PC arithmetic helper for the
// single-step next-PC controller.
package pc_ctrl_pkg;

   localparam logic [5:0] J   = 6'b000010;
   localparam logic [5:0] JAL = 6'b000011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] BNE = 6'b000101;

   localparam logic [31:0] PC_INCREMENT = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // Word offset from a 16-bit branch immediate, sign-extended to 32 bits.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_ctrl_if.sv
// PC datapath bundle between the program counter/instruction memory side
// (master) and the next-PC controller (slave).
interface next_pc_ctrl_if;

   logic [31:0] PcQ;
   logic [31:0] Instr;
   logic        Zero;
   logic [31:0] NextPc;
   logic        PcEnable;
   logic        Jump;
   logic        Branch;

   modport master (
      output PcQ,
      output Instr,
      output Zero,
      input  NextPc,
      input  PcEnable,
      input  Jump,
      input  Branch
   );

   modport slave (
      input  PcQ,
      input  Instr,
      input  Zero,
      output NextPc,
      output PcEnable,
      output Jump,
      output Branch
   );

endinterface

// File: rtl/next_pc_ctrl_step_debounce.sv
// Push-button conditioning: two-flop synchronizer, level debounce and a
// one-cycle pulse on each accepted press.
module step_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Step,
   output logic StepPulse
);

   localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync_0;
   logic        sync_1;
   logic        level;
   logic        level_q;
   logic [15:0] stable_count;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sync_0       <= 1'b0;
         sync_1       <= 1'b0;
         level        <= 1'b0;
         level_q      <= 1'b0;
         stable_count <= '0;
      end else begin
         sync_0  <= Step;
         sync_1  <= sync_0;
         level_q <= level;
         // Any sample agreeing with the accepted level restarts the run.
         if (sync_1 == level) begin
            stable_count <= '0;
         end else if (stable_count == LAST_COUNT) begin
            level        <= sync_1;
            stable_count <= '0;
         end else begin
            stable_count <= stable_count + 16'd1;
         end
      end
   end

   assign StepPulse = level & ~level_q;

endmodule

// File: rtl/next_pc_ctrl.sv
// Single-step next-PC controller: each accepted button press loads PC+4,
// then reloads the jump/branch target one cycle later if the new instruction transfers control.
module next_pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Step,
   next_pc_ctrl_if.slave        pc,
   output logic                 Busy,
   output logic [15:0]          StepCount
);

   state_t      state;
   state_t      state_next;
   logic        pending;
   logic        pending_next;
   logic        step_pulse;
   logic        start_step;
   logic [15:0] step_count;
   logic [5:0]  opcode;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] branch_target;

   step_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_debounce (
      .Clk       (Clk),
      .Rst       (Rst),
      .Step      (Step),
      .StepPulse (step_pulse)
   );

   assign opcode    = pc.Instr[31:26];
   assign pc.Jump   = (opcode == J) || (opcode == JAL);
   assign pc.Branch = ((opcode == BEQ) &&  pc.Zero) ||
                      ((opcode == BNE) && !pc.Zero);

   assign pc_plus4      = pc.PcQ + PC_INCREMENT;
   assign jump_target   = {pc_plus4[31:28], pc.Instr[25:0], 2'b00};
   assign branch_target = pc_plus4 + branch_offset(pc.Instr[15:0]);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= IDLE;
         pending <= 1'b0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
      end
   end

   always_comb begin
      state_next   = state;
      pending_next = pending;
      start_step   = 1'b0;
      pc.PcEnable  = 1'b0;
      pc.NextPc    = pc_plus4;
      case (state)
         IDLE: begin
            if (step_pulse || pending) begin
               state_next   = STEP;
               pending_next = 1'b0;
               start_step   = 1'b1;
            end
         end
         STEP: begin
            state_next  = CHECK;
            pc.PcEnable = 1'b1;
            if (step_pulse) begin
               pending_next = 1'b1;
            end
         end
         CHECK: begin
            // PC already holds the incremented value; decode the new instruction.
            state_next  = IDLE;
            pc.PcEnable = pc.Jump | pc.Branch;
            if (pc.Jump) begin
               pc.NextPc = jump_target;
            end else if (pc.Branch) begin
               pc.NextPc = branch_target;
            end
            if (step_pulse) begin
               pending_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         step_count <= '0;
      end else if (start_step) begin
         step_count <= step_count + 16'd1;
      end
   end

   assign StepCount = step_count;
   assign Busy      = (state != IDLE);

endmodule
